// File: rtl/c432_chan_scheduler.sv
// ----------------------------------------------------------------------------
// c432_chan_scheduler
//
// Request scheduler for the 27-channel c432 priority path: three groups
// (A, B, C) of nine channels each. One 9-bit enable mask applies to all three
// groups. Request pulses are latched into pending registers. One channel at a
// time wins arbitration and is offered to the service logic on a valid/ack
// handshake.
//
// Priority is starved C > starved B > A > B > C. Within a group the lowest
// eligible index wins. B and C each have a counter of accepted grants made to
// higher groups while they waited. When a counter reaches STARVE_LIMIT, that
// group is promoted.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   e_mask[8:0]  channel enable; bit i qualifies A[i], B[i] and C[i]
//   a_req[8:0]   group A request bits, sampled on every edge
//   b_req[8:0]   group B request bits
//   c_req[8:0]   group C request bits
//   grant_ack    consumer accepts the current grant (ignored unless valid)
//   grant_valid  grant_group / grant_chan are valid and held stable
//   grant_group  01=A 10=B 11=C 00=none
//   grant_chan   granted channel index 0..8
//   timeout_err  one-cycle pulse when a grant is withdrawn for lack of ack
//   busy         FSM is in ARB or GRANT
// ----------------------------------------------------------------------------
module c432_chan_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] e_mask,
    input  logic [8:0] a_req,
    input  logic [8:0] b_req,
    input  logic [8:0] c_req,
    input  logic       grant_ack,
    output logic       grant_valid,
    output logic [1:0] grant_group,
    output logic [3:0] grant_chan,
    output logic       timeout_err,
    output logic       busy
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    // The timer only has to reach ACK_TIMEOUT-1.
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [SW-1:0] SL      = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : {TW{1'b0}};
    localparam bit            STARVE_ON  = (STARVE_LIMIT != 0);
    localparam bit            TIMEOUT_ON = (ACK_TIMEOUT != 0);

    localparam logic [1:0] GRP_NONE = 2'b00;
    localparam logic [1:0] GRP_A    = 2'b01;
    localparam logic [1:0] GRP_B    = 2'b10;
    localparam logic [1:0] GRP_C    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t        state_r, state_nxt;
    logic [8:0]    pa_r, pb_r, pc_r;
    logic [8:0]    pa_nxt, pb_nxt, pc_nxt;
    logic [8:0]    clr_a_s, clr_b_s, clr_c_s;
    logic [SW-1:0] sc_b_r, sc_c_r, sc_b_nxt, sc_c_nxt;
    logic [TW-1:0] timer_r, timer_nxt;
    logic          grant_valid_r, grant_valid_nxt;
    logic [1:0]    grant_group_r, grant_group_nxt;
    logic [3:0]    grant_chan_r, grant_chan_nxt;
    logic          timeout_err_r, timeout_err_nxt;
    logic          busy_r;

    logic [8:0]    elig_a_s, elig_b_s, elig_c_s;
    logic          any_a_s, any_b_s, any_c_s, any_elig_s;
    logic          starved_b_s, starved_c_s;
    logic          win_valid_s;
    logic [1:0]    win_group_s;
    logic [3:0]    win_chan_s;
    logic [8:0]    gnt_onehot_s;

    // Returns the index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_idx(input logic [8:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Increments a starve counter and saturates it at STARVE_LIMIT.
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        if (v >= SL) begin
            r = SL;
        end else begin
            r = v + {{(SW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Masked pending bits stay in the pending registers; they are only hidden here.
    assign elig_a_s   = pa_r & e_mask;
    assign elig_b_s   = pb_r & e_mask;
    assign elig_c_s   = pc_r & e_mask;
    assign any_a_s    = |elig_a_s;
    assign any_b_s    = |elig_b_s;
    assign any_c_s    = |elig_c_s;
    assign any_elig_s = any_a_s | any_b_s | any_c_s;

    assign starved_b_s = STARVE_ON && (sc_b_r == SL);
    assign starved_c_s = STARVE_ON && (sc_c_r == SL);

    assign gnt_onehot_s = 9'b000000001 << grant_chan_r;

    // Winner selection: starved C, then starved B, then plain A > B > C.
    always_comb begin
        win_valid_s = 1'b1;
        win_group_s = GRP_NONE;
        win_chan_s  = 4'd0;
        if (starved_c_s && any_c_s) begin
            win_group_s = GRP_C;
            win_chan_s  = lowest_idx(elig_c_s);
        end else if (starved_b_s && any_b_s) begin
            win_group_s = GRP_B;
            win_chan_s  = lowest_idx(elig_b_s);
        end else if (any_a_s) begin
            win_group_s = GRP_A;
            win_chan_s  = lowest_idx(elig_a_s);
        end else if (any_b_s) begin
            win_group_s = GRP_B;
            win_chan_s  = lowest_idx(elig_b_s);
        end else if (any_c_s) begin
            win_group_s = GRP_C;
            win_chan_s  = lowest_idx(elig_c_s);
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next state, next grant outputs, pending-clear vectors and starve counter updates.
    always_comb begin
        state_nxt       = state_r;
        grant_valid_nxt = grant_valid_r;
        grant_group_nxt = grant_group_r;
        grant_chan_nxt  = grant_chan_r;
        timer_nxt       = timer_r;
        timeout_err_nxt = 1'b0;
        sc_b_nxt        = sc_b_r;
        sc_c_nxt        = sc_c_r;
        clr_a_s         = 9'd0;
        clr_b_s         = 9'd0;
        clr_c_s         = 9'd0;
        case (state_r)
            S_IDLE: begin
                grant_valid_nxt = 1'b0;
                grant_group_nxt = GRP_NONE;
                grant_chan_nxt  = 4'd0;
                if (any_elig_s) begin
                    state_nxt = S_ARB;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ARB: begin
                // The mask may have changed since IDLE; an empty set means no grant.
                if (win_valid_s) begin
                    state_nxt       = S_GRANT;
                    grant_valid_nxt = 1'b1;
                    grant_group_nxt = win_group_s;
                    grant_chan_nxt  = win_chan_s;
                    timer_nxt       = {TW{1'b0}};
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (grant_ack) begin
                    state_nxt       = S_IDLE;
                    grant_valid_nxt = 1'b0;
                    grant_group_nxt = GRP_NONE;
                    grant_chan_nxt  = 4'd0;
                    case (grant_group_r)
                        GRP_A: begin
                            clr_a_s = gnt_onehot_s;
                            if (any_b_s) begin
                                sc_b_nxt = sat_inc(sc_b_r);
                            end else begin
                                sc_b_nxt = sc_b_r;
                            end
                            if (any_c_s) begin
                                sc_c_nxt = sat_inc(sc_c_r);
                            end else begin
                                sc_c_nxt = sc_c_r;
                            end
                        end
                        GRP_B: begin
                            clr_b_s  = gnt_onehot_s;
                            sc_b_nxt = {SW{1'b0}};
                            if (any_c_s) begin
                                sc_c_nxt = sat_inc(sc_c_r);
                            end else begin
                                sc_c_nxt = sc_c_r;
                            end
                        end
                        GRP_C: begin
                            clr_c_s  = gnt_onehot_s;
                            sc_c_nxt = {SW{1'b0}};
                        end
                        default: begin
                            clr_a_s = 9'd0;
                        end
                    endcase
                end else if (TIMEOUT_ON && (timer_r == TO_LAST)) begin
                    // Withdraw the grant but keep the pending bit for a retry.
                    state_nxt       = S_IDLE;
                    grant_valid_nxt = 1'b0;
                    grant_group_nxt = GRP_NONE;
                    grant_chan_nxt  = 4'd0;
                    timeout_err_nxt = 1'b1;
                end else if (TIMEOUT_ON) begin
                    timer_nxt = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    timer_nxt = timer_r;
                end
            end
            default: begin
                state_nxt       = S_IDLE;
                grant_valid_nxt = 1'b0;
                grant_group_nxt = GRP_NONE;
                grant_chan_nxt  = 4'd0;
            end
        endcase
    end

    // A request on the same edge as the clear wins, so a re-request is never lost.
    assign pa_nxt = (pa_r & ~clr_a_s) | a_req;
    assign pb_nxt = (pb_r & ~clr_b_s) | b_req;
    assign pc_nxt = (pc_r & ~clr_c_s) | c_req;

    // State, pending, counter and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            pa_r          <= 9'd0;
            pb_r          <= 9'd0;
            pc_r          <= 9'd0;
            sc_b_r        <= {SW{1'b0}};
            sc_c_r        <= {SW{1'b0}};
            timer_r       <= {TW{1'b0}};
            grant_valid_r <= 1'b0;
            grant_group_r <= GRP_NONE;
            grant_chan_r  <= 4'd0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            pa_r          <= pa_nxt;
            pb_r          <= pb_nxt;
            pc_r          <= pc_nxt;
            sc_b_r        <= sc_b_nxt;
            sc_c_r        <= sc_c_nxt;
            timer_r       <= timer_nxt;
            grant_valid_r <= grant_valid_nxt;
            grant_group_r <= grant_group_nxt;
            grant_chan_r  <= grant_chan_nxt;
            timeout_err_r <= timeout_err_nxt;
            busy_r        <= (state_nxt != S_IDLE);
        end
    end

    assign grant_valid = grant_valid_r;
    assign grant_group = grant_group_r;
    assign grant_chan  = grant_chan_r;
    assign timeout_err = timeout_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_c432_chan_scheduler.sv
// ----------------------------------------------------------------------------
// tb_c432_chan_scheduler
//
// Directed bench for c432_chan_scheduler. dut0 uses the default parameters.
// dut1 uses STARVE_LIMIT=2 and ACK_TIMEOUT=8. Both instances share the same
// stimulus. Every scenario starts from a reset so that the two instances are
// aligned again.
//
// Inputs are driven just after the falling edge. Outputs are sampled at the
// falling edge, which is half a cycle after the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_c432_chan_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] e_mask = 9'h1FF;
    logic [8:0] a_req = 9'h000;
    logic [8:0] b_req = 9'h000;
    logic [8:0] c_req = 9'h000;
    logic       grant_ack = 1'b0;

    logic       gv0, te0, busy0, gv1, te1, busy1;
    logic [1:0] gg0, gg1;
    logic [3:0] gc0, gc1;

    int vecs = 0;
    int errs = 0;

    c432_chan_scheduler dut0 (
        .clk(clk), .rst_n(rst_n), .e_mask(e_mask),
        .a_req(a_req), .b_req(b_req), .c_req(c_req), .grant_ack(grant_ack),
        .grant_valid(gv0), .grant_group(gg0), .grant_chan(gc0),
        .timeout_err(te0), .busy(busy0)
    );

    c432_chan_scheduler #(.STARVE_LIMIT(2), .ACK_TIMEOUT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .e_mask(e_mask),
        .a_req(a_req), .b_req(b_req), .c_req(c_req), .grant_ack(grant_ack),
        .grant_valid(gv1), .grant_group(gg1), .grant_chan(gc1),
        .timeout_err(te1), .busy(busy1)
    );

    // Free-running clock, 10-unit period.
    always #5 clk = ~clk;

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        a_req = 9'h000; b_req = 9'h000; c_req = 9'h000;
        grant_ack = 1'b0;
        e_mask = 9'h1FF;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic pulse(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        a_req = a; b_req = b; c_req = c;
        tick;
        a_req = 9'h000; b_req = 9'h000; c_req = 9'h000;
    endtask

    task automatic wait_valid(input bit sel, input int limit, output int n);
        n = 0;
        while (((sel ? gv1 : gv0) !== 1'b1) && (n < limit)) begin
            tick;
            n++;
        end
    endtask

    task automatic do_ack;
        grant_ack = 1'b1;
        tick;
        grant_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        vecs++;
        if ({gv0, gg0, gc0, te0, busy0} !== 9'd0) begin
            errs++; $display("FAIL reset_dut0: got %h want 000", {gv0, gg0, gc0, te0, busy0});
        end
        do_reset;
        vecs++;
        if ({gv1, gg1, gc1, te1, busy1} !== 9'd0) begin
            errs++; $display("FAIL reset_dut1: got %h want 000", {gv1, gg1, gc1, te1, busy1});
        end
        vecs++;
        if ({dut0.pa_r, dut0.pb_r, dut0.pc_r} !== 27'd0) begin
            errs++; $display("FAIL reset_pending: got %h want 0", {dut0.pa_r, dut0.pb_r, dut0.pc_r});
        end
    endtask

    task automatic test_single_grant;
        do_reset;
        pulse(9'h010, 9'h000, 9'h000);
        vecs++;
        if ({gv0, busy0} !== 2'b00) begin
            errs++; $display("FAIL single_t0: got %b want 00", {gv0, busy0});
        end
        tick;
        vecs++;
        if ({gv0, busy0} !== 2'b01) begin
            errs++; $display("FAIL single_arb: got %b want 01", {gv0, busy0});
        end
        tick;
        vecs++;
        if ({gv0, gg0, gc0} !== {1'b1, 2'b01, 4'd4}) begin
            errs++; $display("FAIL single_grant: got %h want %h", {gv0, gg0, gc0}, {1'b1, 2'b01, 4'd4});
        end
        do_ack;
        vecs++;
        if ({gv0, dut0.pa_r} !== 10'd0) begin
            errs++; $display("FAIL single_ack: got %h want 000", {gv0, dut0.pa_r});
        end
    endtask

    task automatic test_group_order;
        logic [6:0] exp [3];
        int n;
        exp[0] = {1'b1, 2'b01, 4'd0};
        exp[1] = {1'b1, 2'b10, 4'd1};
        exp[2] = {1'b1, 2'b11, 4'd2};
        do_reset;
        pulse(9'h001, 9'h002, 9'h004);
        for (int i = 0; i < 3; i++) begin
            wait_valid(1'b0, 10, n);
            vecs++;
            if (n !== 2) begin
                errs++; $display("FAIL order_latency%0d: got %0d want 2", i, n);
            end
            vecs++;
            if ({gv0, gg0, gc0} !== exp[i]) begin
                errs++; $display("FAIL order_grant%0d: got %h want %h", i, {gv0, gg0, gc0}, exp[i]);
            end
            do_ack;
        end
        tick;
        vecs++;
        if ({gv0, busy0} !== 2'b00) begin
            errs++; $display("FAIL order_idle: got %b want 00", {gv0, busy0});
        end
    endtask

    task automatic test_mask;
        int n;
        do_reset;
        e_mask = 9'h0FF;
        pulse(9'h000, 9'h100, 9'h000);
        tick; tick; tick; tick;
        vecs++;
        if ({gv0, busy0} !== 2'b00) begin
            errs++; $display("FAIL mask_blocked: got %b want 00", {gv0, busy0});
        end
        vecs++;
        if (dut0.pb_r !== 9'h100) begin
            errs++; $display("FAIL mask_retained: got %h want 100", dut0.pb_r);
        end
        e_mask = 9'h1FF;
        wait_valid(1'b0, 10, n);
        vecs++;
        if ({n[3:0], gv0, gg0, gc0} !== {4'd2, 1'b1, 2'b10, 4'd8}) begin
            errs++; $display("FAIL mask_grant: got %h want %h", {n[3:0], gv0, gg0, gc0}, {4'd2, 1'b1, 2'b10, 4'd8});
        end
        do_ack;
        vecs++;
        if (dut0.pb_r !== 9'h000) begin
            errs++; $display("FAIL mask_clear: got %h want 000", dut0.pb_r);
        end
    endtask

    task automatic test_starve;
        int n;
        do_reset;
        pulse(9'h001, 9'h000, 9'h001);
        for (int i = 0; i < 2; i++) begin
            wait_valid(1'b1, 10, n);
            vecs++;
            if ({n[3:0], gv1, gg1, gc1} !== {4'd2, 1'b1, 2'b01, 4'd0}) begin
                errs++; $display("FAIL starve_a%0d: got %h want %h", i, {n[3:0], gv1, gg1, gc1}, {4'd2, 1'b1, 2'b01, 4'd0});
            end
            // Re-request A on the ack edge.
            a_req = 9'h001;
            grant_ack = 1'b1;
            tick;
            a_req = 9'h000;
            grant_ack = 1'b0;
            vecs++;
            if (dut1.sc_c_r !== 2'(i + 1)) begin
                errs++; $display("FAIL starve_cnt%0d: got %0d want %0d", i, dut1.sc_c_r, i + 1);
            end
        end
        wait_valid(1'b1, 10, n);
        vecs++;
        if ({n[3:0], gv1, gg1, gc1} !== {4'd2, 1'b1, 2'b11, 4'd0}) begin
            errs++; $display("FAIL starve_c: got %h want %h", {n[3:0], gv1, gg1, gc1}, {4'd2, 1'b1, 2'b11, 4'd0});
        end
        // With the default limit of 4, C is not promoted yet.
        vecs++;
        if ({gv0, gg0, gc0} !== {1'b1, 2'b01, 4'd0}) begin
            errs++; $display("FAIL starve_default_a: got %h want %h", {gv0, gg0, gc0}, {1'b1, 2'b01, 4'd0});
        end
        do_ack;
        vecs++;
        if (dut1.sc_c_r !== 2'd0) begin
            errs++; $display("FAIL starve_cnt_clr: got %0d want 0", dut1.sc_c_r);
        end
        wait_valid(1'b1, 10, n);
        vecs++;
        if ({gv1, gg1, gc1} !== {1'b1, 2'b01, 4'd0}) begin
            errs++; $display("FAIL starve_a_after: got %h want %h", {gv1, gg1, gc1}, {1'b1, 2'b01, 4'd0});
        end
        do_ack;
        vecs++;
        if ({dut1.pa_r, dut1.pc_r} !== 18'd0) begin
            errs++; $display("FAIL starve_drain: got %h want 0", {dut1.pa_r, dut1.pc_r});
        end
    endtask

    task automatic test_timeout;
        int n;
        int cnt;
        do_reset;
        pulse(9'h002, 9'h000, 9'h000);
        wait_valid(1'b1, 10, n);
        vecs++;
        if ({n[3:0], gv1, gg1, gc1} !== {4'd2, 1'b1, 2'b01, 4'd1}) begin
            errs++; $display("FAIL timeout_grant: got %h want %h", {n[3:0], gv1, gg1, gc1}, {4'd2, 1'b1, 2'b01, 4'd1});
        end
        cnt = 1;
        while (cnt < 20) begin
            tick;
            if (gv1 === 1'b1) begin
                cnt++;
            end else begin
                break;
            end
        end
        vecs++;
        if (cnt !== 8) begin
            errs++; $display("FAIL timeout_len: got %0d want 8", cnt);
        end
        vecs++;
        if (te1 !== 1'b1) begin
            errs++; $display("FAIL timeout_pulse: got %b want 1", te1);
        end
        tick;
        vecs++;
        if ({te1, gv1} !== 2'b00) begin
            errs++; $display("FAIL timeout_pulse_end: got %b want 00", {te1, gv1});
        end
        tick;
        vecs++;
        if ({gv1, gg1, gc1} !== {1'b1, 2'b01, 4'd1}) begin
            errs++; $display("FAIL timeout_regrant: got %h want %h", {gv1, gg1, gc1}, {1'b1, 2'b01, 4'd1});
        end
        do_ack;
    endtask

    task automatic test_async_reset;
        int n;
        do_reset;
        pulse(9'h001, 9'h000, 9'h000);
        wait_valid(1'b0, 10, n);
        vecs++;
        if (gv0 !== 1'b1) begin
            errs++; $display("FAIL areset_pre: got %b want 1", gv0);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({gv0, gg0, gc0, te0, busy0, gv1, busy1} !== 11'd0) begin
            errs++; $display("FAIL areset_now: got %h want 000", {gv0, gg0, gc0, te0, busy0, gv1, busy1});
        end
        #1 rst_n = 1'b1;
        tick; tick; tick;
        vecs++;
        if ({gv0, busy0} !== 2'b00) begin
            errs++; $display("FAIL areset_quiet: got %b want 00", {gv0, busy0});
        end
        pulse(9'h020, 9'h000, 9'h000);
        wait_valid(1'b0, 10, n);
        vecs++;
        if ({n[3:0], gv0, gg0, gc0} !== {4'd2, 1'b1, 2'b01, 4'd5}) begin
            errs++; $display("FAIL areset_newreq: got %h want %h", {n[3:0], gv0, gg0, gc0}, {4'd2, 1'b1, 2'b01, 4'd5});
        end
        do_ack;
    endtask

    // Scenario sequence.
    initial begin
        test_reset;
        test_single_grant;
        test_group_order;
        test_mask;
        test_starve;
        test_timeout;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
